// File: rtl/rca_pkg.sv
// Shared types for the ripple-carry adder datapath: adder width, sequencer
// state encoding and the operand bundle that is driven into the adder.
package rca_pkg;

  localparam int RCA_WIDTH = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } rca_seq_state_t;

  typedef struct packed {
    logic [RCA_WIDTH-1:0] a;
    logic [RCA_WIDTH-1:0] b;
    logic                 cin;
  } rca_operand_t;

endpackage

// File: rtl/rca_op_sequencer.sv
// Operand sequencer around an external combinational ripple-carry adder:
// registers operands, waits SETTLE_CYCLES, captures sum/carry for downstream.
module rca_op_sequencer
  import rca_pkg::*;
#(
  parameter int WIDTH         = RCA_WIDTH,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_acc,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic [7:0]       op_count
);

  // The operand bundle is sized by the package, so WIDTH must match RCA_WIDTH.
  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  rca_seq_state_t r_state;
  rca_operand_t   r_op;
  logic [3:0]     r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_out_sum;
  logic           r_out_cout;
  logic           r_out_valid;
  logic [7:0]     r_op_count;
  logic           w_in_ready;

  assign w_in_ready = (r_state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_op        <= '0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_out_sum   <= '0;
      r_out_cout  <= 1'b0;
      r_out_valid <= 1'b0;
      r_op_count  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_op.a   <= in_acc ? r_acc : in_a;
            r_op.b   <= in_b;
            r_op.cin <= in_cin;
            r_cnt    <= CNT_INIT;
            r_state  <= SETTLE;
          end
        end
        SETTLE: begin
          if (r_cnt == 4'd0) begin
            r_out_sum   <= add_sum;
            r_out_cout  <= add_cout;
            r_acc       <= add_sum;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        DONE: begin
          // Return to IDLE only; the next operand is taken a cycle later.
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            if (r_op_count != 8'hFF) r_op_count <= r_op_count + 8'd1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign add_a     = r_op.a;
  assign add_b     = r_op.b;
  assign add_cin   = r_op.cin;
  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_cout  = r_out_cout;
  assign op_count  = r_op_count;

endmodule

// File: tb/tb_rca_op_sequencer.sv
// Self-checking bench: two sequencers (settle 1 and 4) each driving a
// behavioural adder, compared against an arithmetic reference model.
module tb_rca_op_sequencer;

  localparam int W = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance with SETTLE_CYCLES=1
  logic         in_valid, in_ready, in_cin, in_acc;
  logic [W-1:0] in_a, in_b;
  logic [W-1:0] add_a, add_b, add_sum;
  logic         add_cin, add_cout;
  logic         out_valid, out_ready, out_cout;
  logic [W-1:0] out_sum;
  logic [7:0]   op_count;

  // Instance with SETTLE_CYCLES=4
  logic         in_valid_4, in_ready_4, in_cin_4, in_acc_4;
  logic [W-1:0] in_a_4, in_b_4;
  logic [W-1:0] add_a_4, add_b_4, add_sum_4;
  logic         add_cin_4, add_cout_4;
  logic         out_valid_4, out_ready_4, out_cout_4;
  logic [W-1:0] out_sum_4;
  logic [7:0]   op_count_4;

  assign {add_cout, add_sum}     = {1'b0, add_a} + {1'b0, add_b} + {3'b000, add_cin};
  assign {add_cout_4, add_sum_4} = {1'b0, add_a_4} + {1'b0, add_b_4} + {3'b000, add_cin_4};

  rca_op_sequencer #(.WIDTH(W), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_cin(in_cin), .in_acc(in_acc),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .op_count(op_count)
  );

  rca_op_sequencer #(.WIDTH(W), .SETTLE_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_4), .in_ready(in_ready_4), .in_a(in_a_4), .in_b(in_b_4),
    .in_cin(in_cin_4), .in_acc(in_acc_4),
    .add_a(add_a_4), .add_b(add_b_4), .add_cin(add_cin_4),
    .add_sum(add_sum_4), .add_cout(add_cout_4),
    .out_valid(out_valid_4), .out_ready(out_ready_4),
    .out_sum(out_sum_4), .out_cout(out_cout_4), .op_count(op_count_4)
  );

  int vec  = 0;
  int errs = 0;

  // Reference model state for the settle-1 instance
  int model_acc = 0;
  int model_cnt = 0;

  // Returns the full arithmetic result (sum in bits 2:0, carry in bit 3)
  // and updates the accumulator and completed-op count.
  function automatic int model_op(input int a, input int b, input int cin, input int acc);
    int opa, r;
    opa = acc ? model_acc : a;
    r = opa + b + cin;
    model_acc = r % 8;
    if (model_cnt < 255) model_cnt++;
    return r;
  endfunction

  // Present one operand (caller is one tick after an edge, DUT in IDLE),
  // wait for the result and complete the output handshake.
  task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic acc,
                          output logic [W-1:0] s, output logic c, output int lat);
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; in_acc = acc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    s = out_sum; c = out_cout;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1; in_a = 3'd5; in_b = 3'd2; in_cin = 1'b1; in_acc = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vec++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    vec++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vec++; if ({add_a, add_b, add_cin} !== 7'd0) begin errs++; $display("FAIL reset_add: got %0d/%0d/%0d want 0", add_a, add_b, add_cin); end
    vec++; if ({out_sum, out_cout} !== 4'd0) begin errs++; $display("FAIL reset_out: got %0d/%0d want 0", out_sum, out_cout); end
    vec++; if (op_count !== 8'd0) begin errs++; $display("FAIL reset_op_count: got %0d want 0", op_count); end
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errs++; $display("FAIL reset_release: got ready=%b valid=%b want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_basic();
    logic [W-1:0] s; logic c; int lat, r;
    r = model_op(3, 2, 0, 0);
    drive_op(3'd3, 3'd2, 1'b0, 1'b0, s, c, lat);
    vec++; if ({c, s} !== 4'(r)) begin errs++; $display("FAIL basic_sum: got %0d/%0d want %0d/%0d", s, c, r % 8, r / 8); end
    vec++; if (lat !== 1) begin errs++; $display("FAIL basic_latency: got %0d want 1", lat); end
    vec++; if (op_count !== 8'(model_cnt)) begin errs++; $display("FAIL basic_op_count: got %0d want %0d", op_count, model_cnt); end
  endtask

  task automatic test_overflow();
    int r;
    r = model_op(7, 1, 1, 0);
    in_valid = 1'b1; in_a = 3'd7; in_b = 3'd1; in_cin = 1'b1; in_acc = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'($urandom); in_a = 3'($urandom); in_b = 3'($urandom);
      in_cin = 1'($urandom); in_acc = 1'($urandom);
      @(posedge clk); #1;
      vec++; if ({add_a, add_b, add_cin} !== 7'b111_001_1) begin errs++; $display("FAIL ovf_add_stable: got %0d/%0d/%0d want 7/1/1", add_a, add_b, add_cin); end
      vec++; if (in_ready !== 1'b0) begin errs++; $display("FAIL ovf_in_ready: got %b want 0", in_ready); end
    end
    vec++; if (out_valid !== 1'b1 || {out_cout, out_sum} !== 4'(r)) begin errs++; $display("FAIL ovf_result: got v=%b %0d/%0d want 1 %0d/%0d", out_valid, out_sum, out_cout, r % 8, r / 8); end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errs++; $display("FAIL ovf_handshake: got v=%b r=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_accumulate();
    logic [W-1:0] s; logic c; int lat, r;
    r = model_op(3, 3, 0, 0);
    drive_op(3'd3, 3'd3, 1'b0, 1'b0, s, c, lat);
    vec++; if ({c, s} !== 4'(r)) begin errs++; $display("FAIL acc_seed: got %0d/%0d want %0d/%0d", s, c, r % 8, r / 8); end
    r = model_op(0, 3, 0, 1);
    drive_op(3'($urandom), 3'd3, 1'b0, 1'b1, s, c, lat);
    vec++; if ({c, s} !== 4'(r)) begin errs++; $display("FAIL acc_chain: got %0d/%0d want %0d/%0d", s, c, r % 8, r / 8); end
    r = model_op(0, 0, 0, 1);
    drive_op(3'($urandom), 3'd0, 1'b0, 1'b1, s, c, lat);
    vec++; if ({c, s} !== 4'(r)) begin errs++; $display("FAIL acc_reg_value: got %0d/%0d want %0d/%0d", s, c, r % 8, r / 8); end
  endtask

  task automatic test_backpressure();
    int r1, r2, lat;
    r1 = model_op(2, 5, 0, 0);
    in_valid = 1'b1; in_a = 3'd2; in_b = 3'd5; in_cin = 1'b0; in_acc = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_a = 3'd4; in_b = 3'd1; in_cin = 1'b1;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 64) begin @(posedge clk); #1; lat++; end
    vec++; if (lat !== 1) begin errs++; $display("FAIL bp_latency: got %0d want 1", lat); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      vec++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errs++; $display("FAIL bp_hold_ctrl: got r=%b v=%b want 0/1", in_ready, out_valid); end
      vec++; if ({out_cout, out_sum} !== 4'(r1)) begin errs++; $display("FAIL bp_hold_data: got %0d/%0d want %0d/%0d", out_sum, out_cout, r1 % 8, r1 / 8); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errs++; $display("FAIL bp_bubble: got r=%b v=%b want 1/0", in_ready, out_valid); end
    vec++; if (op_count !== 8'(model_cnt)) begin errs++; $display("FAIL bp_op_count: got %0d want %0d", op_count, model_cnt); end
    r2 = model_op(4, 1, 1, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    vec++; if (in_ready !== 1'b0 || add_a !== 3'd4 || add_b !== 3'd1) begin errs++; $display("FAIL bp_second_accept: got r=%b a=%0d b=%0d want 0/4/1", in_ready, add_a, add_b); end
    lat = 0;
    while (out_valid !== 1'b1 && lat < 64) begin @(posedge clk); #1; lat++; end
    vec++; if ({out_cout, out_sum} !== 4'(r2)) begin errs++; $display("FAIL bp_second_result: got %0d/%0d want %0d/%0d", out_sum, out_cout, r2 % 8, r2 / 8); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [W-1:0] s, a, b; logic c, cin, acc; int lat, r;
    for (int i = 0; i < 40; i++) begin
      a = 3'($urandom); b = 3'($urandom); cin = 1'($urandom); acc = 1'($urandom);
      r = model_op(a, b, cin, acc);
      drive_op(a, b, cin, acc, s, c, lat);
      vec++; if ({c, s} !== 4'(r) || lat !== 1) begin errs++; $display("FAIL rand_op%0d: got %0d/%0d lat %0d want %0d/%0d lat 1", i, s, c, lat, r % 8, r / 8); end
    end
    vec++; if (op_count !== 8'(model_cnt)) begin errs++; $display("FAIL rand_op_count: got %0d want %0d", op_count, model_cnt); end
  endtask

  task automatic test_settle_reset();
    int r;
    r = 5 + 6 + 1;
    in_valid_4 = 1'b1; in_a_4 = 3'd5; in_b_4 = 3'd6; in_cin_4 = 1'b1; in_acc_4 = 1'b0;
    out_ready_4 = 1'b0;
    @(posedge clk); #1;
    in_valid_4 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      if (k < 4) begin
        vec++; if (out_valid_4 !== 1'b0) begin errs++; $display("FAIL settle4_early_edge%0d: got %b want 0", k, out_valid_4); end
      end else begin
        vec++; if (out_valid_4 !== 1'b1 || {out_cout_4, out_sum_4} !== 4'(r)) begin errs++; $display("FAIL settle4_capture: got v=%b %0d/%0d want 1 %0d/%0d", out_valid_4, out_sum_4, out_cout_4, r % 8, r / 8); end
      end
    end
    out_ready_4 = 1'b1;
    @(posedge clk); #1;
    out_ready_4 = 1'b0;
    in_valid_4 = 1'b1; in_a_4 = 3'd1; in_b_4 = 3'd1; in_cin_4 = 1'b0;
    @(posedge clk); #1;
    in_valid_4 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    model_acc = 0; model_cnt = 0;
    #1;
    vec++; if (in_ready_4 !== 1'b1 || out_valid_4 !== 1'b0) begin errs++; $display("FAIL rst_mid_ctrl: got r=%b v=%b want 1/0", in_ready_4, out_valid_4); end
    vec++; if ({add_a_4, add_b_4, add_cin_4, out_sum_4, out_cout_4, op_count_4} !== 19'd0) begin errs++; $display("FAIL rst_mid_regs: got a=%0d b=%0d s=%0d cnt=%0d want 0", add_a_4, add_b_4, out_sum_4, op_count_4); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      vec++; if (out_valid_4 !== 1'b0 || in_ready_4 !== 1'b1) begin errs++; $display("FAIL rst_no_partial%0d: got v=%b r=%b want 0/1", k, out_valid_4, in_ready_4); end
    end
  endtask

  task automatic test_saturation();
    logic [W-1:0] s, a, b; logic c, cin; int lat, r;
    for (int i = 0; i < 260; i++) begin
      a = 3'($urandom); b = 3'($urandom); cin = 1'($urandom);
      r = model_op(a, b, cin, 0);
      drive_op(a, b, cin, 1'b0, s, c, lat);
      vec++; if (op_count !== 8'(model_cnt) || {c, s} !== 4'(r)) begin errs++; $display("FAIL sat_op%0d: got cnt=%0d %0d/%0d want cnt=%0d %0d/%0d", i, op_count, s, c, model_cnt, r % 8, r / 8); end
    end
    vec++; if (op_count !== 8'd255) begin errs++; $display("FAIL sat_final: got %0d want 255", op_count); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_acc = 1'b0; out_ready = 1'b0;
    in_valid_4 = 1'b0; in_a_4 = '0; in_b_4 = '0; in_cin_4 = 1'b0; in_acc_4 = 1'b0; out_ready_4 = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_accumulate();
    test_backpressure();
    test_random();
    test_settle_reset();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
